// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared frog types and screen geometry
package frog_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int FROG_SIZE = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOP,
        S_DEAD,
        S_GAME_OVER
    } state_t;

    // Numeric order doubles as priority: a smaller non-zero code wins.
    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

endpackage

// File: rtl/frog_controller_btn_request.sv
// rtl/frog_controller_btn_request.sv - button edge detectors and priority pending move
module btn_request
    import frog_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic accept,
    input  logic clear,
    output dir_t req,
    output logic any_edge
);

    logic [3:0] btn_q;
    logic [3:0] rise;
    dir_t       pending;
    dir_t       edge_dir;

    assign rise     = {btn_up, btn_down, btn_left, btn_right} & ~btn_q;
    assign any_edge = |rise;

    // req merges this cycle's edges so a press coinciding with the tick is seen at once.
    always_comb begin
        edge_dir = DIR_NONE;
        if (rise[3])      edge_dir = DIR_UP;
        else if (rise[2]) edge_dir = DIR_DOWN;
        else if (rise[1]) edge_dir = DIR_LEFT;
        else if (rise[0]) edge_dir = DIR_RIGHT;
        req = pending;
        if (accept && edge_dir != DIR_NONE &&
            (pending == DIR_NONE || edge_dir < pending))
            req = edge_dir;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q   <= 4'b0000;
            pending <= DIR_NONE;
        end else begin
            btn_q   <= {btn_up, btn_down, btn_left, btn_right};
            pending <= clear ? DIR_NONE : req;
        end
    end

endmodule

// File: rtl/frog_controller.sv
// rtl/frog_controller.sv - frog position, hop animation, death and scoring sequencer
module frog_controller #(
    parameter int H_RES        = frog_pkg::H_RES,
    parameter int V_RES        = frog_pkg::V_RES,
    parameter int FROG_SIZE    = frog_pkg::FROG_SIZE,
    parameter int STEP         = 32,
    parameter int HOP_FRAMES   = 4,
    parameter int DEATH_FRAMES = 60,
    parameter int START_X      = 304,
    parameter int START_Y      = 448,
    parameter int LIVES        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collision,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic       frog_visible,
    output logic       hop_active,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over
);

    import frog_pkg::*;

    localparam int HCW = $clog2(HOP_FRAMES + 1);
    localparam int DCW = $clog2(DEATH_FRAMES + 1);
    localparam logic [HCW-1:0] HOP_LAST   = HCW'(HOP_FRAMES - 1);
    localparam logic [DCW-1:0] DEATH_LAST = DCW'(DEATH_FRAMES - 1);
    localparam logic [DCW-1:0] BLINK_MASK = DCW'(7);
    localparam logic [9:0]  INC     = 10'(STEP / HOP_FRAMES);
    localparam logic [9:0]  X_START = 10'(START_X);
    localparam logic [9:0]  Y_START = 10'(START_Y);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] X_MAX   = 11'(H_RES - FROG_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_RES - FROG_SIZE);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    state_t         state;
    dir_t           req;
    dir_t           hop_dir;
    dir_t           move_dir;
    logic           any_edge;
    logic           req_legal;
    logic [HCW-1:0] hop_cnt;
    logic [DCW-1:0] death_cnt;
    logic [9:0]     nx;
    logic [9:0]     ny;
    logic [10:0]    x11;
    logic [10:0]    y11;

    btn_request u_btn_request (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .accept    (state == S_IDLE),
        .clear     (frame_tick || state != S_IDLE),
        .req       (req),
        .any_edge  (any_edge)
    );

    assign x11 = {1'b0, frog_x};
    assign y11 = {1'b0, frog_y};

    always_comb begin
        case (req)
            DIR_UP:    req_legal = y11 >= STEP11;
            DIR_DOWN:  req_legal = y11 + STEP11 <= Y_MAX;
            DIR_LEFT:  req_legal = x11 >= STEP11;
            DIR_RIGHT: req_legal = x11 + STEP11 <= X_MAX;
            default:   req_legal = 1'b0;
        endcase
    end

    // Next single-frame increment, for either a starting hop or one in flight.
    assign move_dir = (state == S_IDLE) ? req : hop_dir;
    always_comb begin
        nx = frog_x;
        ny = frog_y;
        case (move_dir)
            DIR_UP:    ny = frog_y - INC;
            DIR_DOWN:  ny = frog_y + INC;
            DIR_LEFT:  nx = frog_x - INC;
            DIR_RIGHT: nx = frog_x + INC;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            hop_dir      <= DIR_NONE;
            hop_cnt      <= '0;
            death_cnt    <= '0;
            frog_x       <= X_START;
            frog_y       <= Y_START;
            frog_visible <= 1'b1;
            hop_active   <= 1'b0;
            lives        <= LIVES_INIT;
            score        <= 8'd0;
            game_over    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        if (collision) begin
                            state        <= S_DEAD;
                            lives        <= lives - 2'd1;
                            death_cnt    <= '0;
                            frog_visible <= 1'b0;
                        end else if (req_legal) begin
                            state      <= S_HOP;
                            hop_dir    <= req;
                            frog_x     <= nx;
                            frog_y     <= ny;
                            hop_cnt    <= HCW'(1);
                            hop_active <= 1'b1;
                        end
                    end
                end
                S_HOP: begin
                    if (frame_tick) begin
                        if (collision) begin
                            state        <= S_DEAD;
                            hop_active   <= 1'b0;
                            lives        <= lives - 2'd1;
                            death_cnt    <= '0;
                            frog_visible <= 1'b0;
                        end else begin
                            frog_x  <= nx;
                            frog_y  <= ny;
                            hop_cnt <= hop_cnt + HCW'(1);
                            if (hop_cnt == HOP_LAST) begin
                                state      <= S_IDLE;
                                hop_active <= 1'b0;
                                if (ny == 10'd0) begin
                                    if (score != 8'hff) score <= score + 8'd1;
                                    frog_x <= X_START;
                                    frog_y <= Y_START;
                                end
                            end
                        end
                    end
                end
                S_DEAD: begin
                    if (frame_tick) begin
                        if (death_cnt == DEATH_LAST) begin
                            frog_x       <= X_START;
                            frog_y       <= Y_START;
                            frog_visible <= 1'b1;
                            if (lives == 2'd0) begin
                                state     <= S_GAME_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            death_cnt <= death_cnt + DCW'(1);
                            // Blink: flip on every 8th frame spent dead.
                            if ((death_cnt & BLINK_MASK) == BLINK_MASK)
                                frog_visible <= ~frog_visible;
                        end
                    end
                end
                S_GAME_OVER: begin
                    if (any_edge) begin
                        state     <= S_IDLE;
                        lives     <= LIVES_INIT;
                        score     <= 8'd0;
                        game_over <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
